clock_run_ctrl: RTL
===================

# clock_run_ctrl

Run-control sequencer for the processor's gated clock domain. Accepts RUN, STEP(N) and HALT commands from the debug/testbench host and produces a registered clock-enable (`core_en`) that gates the free-running 50%-duty clock into the core. The block counts stepped cycles and reports completion. As a build option, it halts on a PC breakpoint. It sits between the clock generator output and the datapath register enables.

## Interface
Parameters:
- `CNT_W`, 16: width of the step count and remaining-step counter.
- `ADDR_W`, 32: width of PC and breakpoint address.

Ports:
- `clk`  in  1  free-running clock from the clock generator.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command strobe.
- `cmd_ready`  out  1  command acceptance; constant 1 after reset.
- `cmd_op`  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT.
- `cmd_count`  in  CNT_W  step count, sampled with STEP.
- `pc`  in  ADDR_W  current core PC.
- `bp_addr`  in  ADDR_W  breakpoint address.
- `bp_valid`  in  1  breakpoint armed.
- `core_en`  out  1  registered enable for core state elements.
- `running`  out  1  high in RUN or STEP.
- `steps_left`  out  CNT_W  remaining STEP cycles.
- `done`  out  1  one-cycle pulse on the return to HALTED.
- `bp_hit`  out  1  one-cycle pulse when a breakpoint causes the halt.
- `err`  out  1  one-cycle pulse when RUN/STEP is issued while not HALTED.

## Operation
- States: HALTED, RUN, STEP. Reset enters HALTED.
- A command is accepted on a `clk` edge with `cmd_valid`=1. NOP does nothing.
- HALTED + RUN: go to RUN.
- HALTED + STEP, N>0: go to STEP and load `steps_left`=N.
- HALTED + STEP, N=0: stay in HALTED; pulse `done` next cycle; `core_en` stays 0.
- HALTED + HALT: no effect; no `done` pulse.
- RUN/STEP + RUN or STEP: ignored; pulse `err`; state and counter unchanged.
- RUN/STEP + HALT: go to HALTED; pulse `done`.
- STEP: `steps_left` decrements on every cycle with `core_en`=1. When an enabled cycle starts with `steps_left`=1, go to HALTED; `steps_left` becomes 0; pulse `done`.
- RUN: no counting; `steps_left` holds 0.
- Simultaneous events: at most one `done` pulse per halt.
  - HALT arriving on the last STEP cycle yields a single `done`.
  - HALT coinciding with a breakpoint match yields `done` and `bp_hit` together.

## Timing
- Reset values: state HALTED, `core_en`=0, `running`=0, `steps_left`=0, `done`=0, `bp_hit`=0, `err`=0.
- Command accepted at edge k: `core_en` rises after edge k and is high in cycle k+1.
- STEP N: `core_en` is high for exactly N consecutive cycles. `done` is high in the first cycle `core_en` is low again.
- HALT accepted at edge k: `core_en` is low from cycle k+1.
- `running` equals `core_en` in every cycle.
- `done`, `bp_hit` and `err` are registered pulses, exactly one cycle wide.
- Reset asserted mid-RUN/STEP: at the next edge, all outputs return to reset values. No `done` pulse is generated.

## Configuration
- `BREAKPOINT_EN` defined:
  - Condition: in RUN or STEP, with `core_en`=1 and `bp_valid`=1 and `pc`==`bp_addr`.
  - Response: go to HALTED; `core_en` is low the next cycle; pulse `done` and `bp_hit`.
  - The match is ignored in the first enabled cycle after entering RUN or STEP, so resuming from a breakpoint makes progress.
- `BREAKPOINT_EN` not defined: `pc`, `bp_addr` and `bp_valid` are ignored, and `bp_hit` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `run_ctrl_pkg` holds:
  - the `run_state_t` enum (HALTED, RUN, STEP);
  - the `cmd_op_t` enum with OP_NOP/OP_RUN/OP_STEP/OP_HALT encodings.
- Sub-module `step_counter`: a loadable CNT_W down-counter with load, decrement-enable and `is_one` flag. The FSM, enable register and pulse registers stay in `clock_run_ctrl`.

## Test plan
- Reset, then STEP N=3 → `core_en` high for exactly 3 cycles, `steps_left` 3→2→1→0, single `done` in the cycle after.
- STEP N=0 → `core_en` never rises, `done` pulses one cycle after acceptance.
- RUN, then HALT 10 cycles later → `core_en` high for exactly 10 cycles, single `done`; a STEP issued during RUN → `err` pulse with the enable pattern unchanged.
- STEP N=5 with HALT on the 5th enabled cycle → `core_en` high for 5 cycles, exactly one `done`.
- With `BREAKPOINT_EN`: `bp_addr`=0x40, `pc` increments by 4 from 0x30 while enabled, RUN → halt after the cycle where `pc`=0x40, `bp_hit`=`done`=1; a second RUN proceeds past 0x40. Without the macro, the same stimulus runs until HALT and `bp_hit` stays 0.
- Reset asserted during STEP N=100 at step 20 → all outputs 0 next cycle, no `done`; a subsequent STEP N=2 behaves normally.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types for the gated-clock run-control sequencer.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      HALTED = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2
   } run_state_t;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_RUN  = 2'b01,
      OP_STEP = 2'b10,
      OP_HALT = 2'b11
   } cmd_op_t;

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter holding the number of STEP cycles still to run.
module step_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clr,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             is_one
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign count  = r_count;
   assign is_one = (r_count == CNT_W'(1));

endmodule

// File: rtl/clock_run_ctrl.sv
// Run-control sequencer producing the registered core clock-enable.
// Build option: BREAKPOINT_EN halts on pc == bp_addr (bp_hit tied low otherwise).
module clock_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic              bp_valid,
   output logic              core_en,
   output logic              running,
   output logic [CNT_W-1:0]  steps_left,
   output logic              done,
   output logic              bp_hit,
   output logic              err
);

   run_state_t       r_state;
   run_state_t       w_next_state;
   logic             r_core_en;
   logic             r_done;
   logic             r_bp_hit;
   logic             r_err;
   logic             w_done_nxt;
   logic             w_bp_hit_nxt;
   logic             w_err_nxt;
   logic             w_load;
   logic             w_clr;
   logic             w_dec;
   logic             w_is_one;
   logic             w_bp_match;
   cmd_op_t          w_cmd;
   logic [CNT_W-1:0] w_count;

   assign w_cmd = cmd_valid ? cmd_op_t'(cmd_op) : OP_NOP;

`ifdef BREAKPOINT_EN
   logic r_first;

   // Suppress the match in the first enabled cycle so a resume at the breakpoint PC progresses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_first <= 1'b0;
      end else begin
         r_first <= (r_state == HALTED) && (w_next_state != HALTED);
      end
   end

   assign w_bp_match = (r_state != HALTED) && r_core_en && bp_valid &&
                       (pc == bp_addr) && !r_first;
`else
   logic w_unused;
   assign w_unused   = ^{pc, bp_addr, bp_valid};
   assign w_bp_match = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= HALTED;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_done_nxt   = 1'b0;
      w_bp_hit_nxt = 1'b0;
      w_err_nxt    = 1'b0;
      w_load       = 1'b0;
      w_clr        = 1'b0;
      w_dec        = 1'b0;
      case (r_state)
         HALTED: begin
            case (w_cmd)
               OP_RUN: w_next_state = RUN;
               OP_STEP: begin
                  if (cmd_count != '0) begin
                     w_next_state = STEP;
                     w_load       = 1'b1;
                  end else begin
                     w_done_nxt = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         RUN, STEP: begin
            w_dec     = (r_state == STEP) && r_core_en;
            w_err_nxt = (w_cmd == OP_RUN) || (w_cmd == OP_STEP);
            // Any mix of HALT, last step and breakpoint collapses into one halt and one done.
            if ((w_cmd == OP_HALT) || w_bp_match || (w_dec && w_is_one)) begin
               w_next_state = HALTED;
               w_done_nxt   = 1'b1;
               w_bp_hit_nxt = w_bp_match;
               w_clr        = 1'b1;
            end
         end
         default: w_next_state = HALTED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_core_en <= 1'b0;
         r_done    <= 1'b0;
         r_bp_hit  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_core_en <= (w_next_state != HALTED);
         r_done    <= w_done_nxt;
         r_bp_hit  <= w_bp_hit_nxt;
         r_err     <= w_err_nxt;
      end
   end

   step_counter #(
      .CNT_W(CNT_W)
   ) u_step_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (w_load),
      .clr      (w_clr),
      .dec      (w_dec),
      .load_val (cmd_count),
      .count    (w_count),
      .is_one   (w_is_one)
   );

   assign cmd_ready  = 1'b1;
   assign core_en    = r_core_en;
   assign running    = r_core_en;
   assign steps_left = w_count;
   assign done       = r_done;
   assign bp_hit     = r_bp_hit;
   assign err        = r_err;

endmodule
